mem_req_queue: RTL and testbench
================================

# mem_req_queue

Request buffer between the core load/store unit and `cache_subsystem`. It absorbs core memory requests while the cache stalls, issues them in order at one per cycle, and tracks which core IDs have a load in flight. It also returns cache responses to the core with a registered stage. It decouples core issue from cache `stall_out` and prevents a core ID from being reused while its load is still pending.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, request address width
- `DATA_WIDTH`, 32, data width (request and response)
- `CREG_ID_BITS`, 3, core ld/st queue ID width
- `DEPTH_BITS`, 2, log2 of queue depth (4 entries)

Ports:
- `clk` in 1: single clock
- `reset` in 1: asynchronous, active-low
- `core_valid_in` in 1: core request valid
- `core_rw_in` in 1: 1 = store, 0 = load
- `core_addr_in` in ADDR_WIDTH: request address
- `core_data_in` in DATA_WIDTH: store data
- `core_id_in` in CREG_ID_BITS: request ID
- `core_accept_out` out 1: request taken this cycle if `core_valid_in`
- `mem_valid_out` out 1: request to cache valid
- `mem_rw_out`, `mem_addr_out`, `mem_data_out`, `mem_id_out` out: request fields to the cache
- `mem_stall_in` in 1: cache `stall_out`
- `mem_ready_in` in 1: cache `ready_out`
- `mem_id_in` in CREG_ID_BITS: cache `id_out`
- `mem_data_in` in DATA_WIDTH: cache `data_out`
- `core_resp_valid` out 1: load data returned
- `core_resp_id` out CREG_ID_BITS: returned ID
- `core_resp_data` out DATA_WIDTH: returned data
- `busy_ids` out 2^CREG_ID_BITS: per-ID busy vector
- `err_out` out 1: sticky; set on a response for a non-busy ID

## Operation
- **FIFO.** Depth 2^DEPTH_BITS. Each entry holds {rw, addr, data, id}. Read and write pointers are DEPTH_BITS+1 wide. Full means the MSBs differ and the lower bits are equal; empty means the pointers are equal. Pointers wrap naturally.
- **Busy vector.** `busy[i]` is set on accept of ID i and stays set until the request is released. A load releases on `mem_ready_in` with `mem_id_in == i`. A store releases at issue, because the cache acks loads only.
- **Accept.** `core_accept_out = ~full & ~busy[core_id_in]`. Both terms come from registered state only, with no combinational path from `mem_stall_in`.
- **Issue.** `mem_valid_out = ~empty & ~mem_stall_in`. The `mem_*` fields come from the head entry. The entry pops at the clock edge where `mem_valid_out` is high.
- **Response.** On `mem_ready_in`, `core_resp_*` is registered at the next edge and the busy bit is cleared. If that ID is not busy, `err_out` is set, `core_resp_valid` is still pulsed, and `busy` is unchanged.
- **Simultaneous events:**
  - Enqueue and issue in the same cycle are both allowed.
  - When full, there is no same-cycle refill.
  - A response clearing ID X and a core request with ID X in the same cycle: the request is rejected and accepted the next cycle.
  - A store issue clearing X and a new X in the same cycle: the new X is likewise rejected.
- **Reset** (asserted at any time, including mid-operation): pointers are 0, `busy` = 0, `err_out` = 0, `core_resp_valid` = 0, `core_resp_id`/`core_resp_data` = 0. In-flight requests are dropped. `mem_valid_out` is 0 because the queue is empty.

## Timing
- Accept-to-issue latency: 1 cycle minimum. A request accepted at edge N appears as `mem_valid_out` during cycle N+1 if not stalled.
- Response latency: 1 cycle. `mem_ready_in` in cycle N gives `core_resp_valid` in cycle N+1, high for exactly one cycle per response.
- Throughput: 1 accept and 1 issue per cycle sustained.
- A stall holds the head entry. The `mem_*` fields stay stable (head unchanged) but `mem_valid_out` is low.

## Configuration
- Macro: `MEM_REQ_BYPASS_EN`.
- **Defined:** when the queue is empty, `mem_stall_in` is low and the core request is accepted, the request drives `mem_*` combinationally in the same cycle. It is not enqueued. The busy rules are unchanged. Accept-to-issue latency is 0. `core_accept_out` remains independent of `mem_stall_in`, and a stalled request enqueues normally.
- **Undefined:** every request passes through the FIFO, with a minimum latency of 1.

## Structure
- Package `mem_req_pkg`:
  - request struct type {rw, addr, data, id}
  - default widths
  - `QUEUE_DEPTH` constant
- Sub-module `mem_req_fifo`: a generic registered FIFO with push/pop/full/empty/head. The busy scoreboard, accept, issue and response logic stay in `mem_req_queue`.

## Test plan
- **Single load:** load ID 2, addr 0x100 accepted at edge 0. Expect `mem_valid_out` with addr 0x100, ID 2 in cycle 1 (cycle 0 with `MEM_REQ_BYPASS_EN`) and `busy[2]` = 1. Then `mem_ready_in` ID 2 with data 0xDEADBEEF gives `core_resp_valid`, ID 2, 0xDEADBEEF one cycle later and `busy[2]` = 0.
- **Full/stall:** hold `mem_stall_in` high and offer IDs 0–5. Expect IDs 0–3 accepted and `core_accept_out` = 0 afterwards. Release the stall: expect issue order 0, 1, 2, 3 on consecutive cycles.
- **ID reuse:** issue load ID 1 with no response, then offer ID 1 again. Expect it rejected until the cycle after `mem_ready_in` ID 1. Also check the same-cycle response + request collision is rejected.
- **Stores:** store ID 4, data 0x55 issues. Expect `busy[4]` to clear at the issue edge and no `core_resp_valid`.
- **Spurious response:** `mem_ready_in` with ID 6 not busy. Expect `err_out` = 1 to stay set until reset and `busy` unchanged.
- **Reset mid-operation:** with 3 entries queued and 2 loads outstanding, assert `reset` asynchronously. Expect all outputs at their reset values immediately, and normal operation after deassertion.

Source files
------------

// File: rtl/mem_req_pkg.sv
// mem_req_pkg: shared widths, depth and request bundle
// for the core-to-cache request queue.
package mem_req_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int ID_W_DEF       = 3;
  localparam int DEPTH_BITS_DEF = 2;
  localparam int QUEUE_DEPTH    = 1 << DEPTH_BITS_DEF;

  typedef struct packed {
    logic                  rw;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
    logic [ID_W_DEF-1:0]   id;
  } mem_req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: generic registered FIFO, 2^DEPTH_BITS entries,
// extra pointer MSB separates full from empty.
module mem_req_fifo
  import mem_req_pkg::*;
#(
  parameter int WIDTH      = $bits(mem_req_t),
  parameter int DEPTH_BITS = DEPTH_BITS_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [DEPTH_BITS:0] r_wptr;
  logic [DEPTH_BITS:0] r_rptr;
  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic                w_push;
  logic                w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  =
    (r_wptr[DEPTH_BITS] != r_rptr[DEPTH_BITS]) &&
    (r_wptr[DEPTH_BITS-1:0] == r_rptr[DEPTH_BITS-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rptr[DEPTH_BITS-1:0]];

  // Pointer advance; both may move in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Entry storage, written at the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr[DEPTH_BITS-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/mem_req_queue.sv
// mem_req_queue: in-order request buffer with per-ID busy tracking.
// Optional same-cycle bypass when empty: MEM_REQ_BYPASS_EN.
module mem_req_queue
  import mem_req_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_W_DEF,
  parameter int DATA_WIDTH   = DATA_W_DEF,
  parameter int CREG_ID_BITS = ID_W_DEF,
  parameter int DEPTH_BITS   = DEPTH_BITS_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         core_valid_in,
  input  logic                         core_rw_in,
  input  logic [ADDR_WIDTH-1:0]        core_addr_in,
  input  logic [DATA_WIDTH-1:0]        core_data_in,
  input  logic [CREG_ID_BITS-1:0]      core_id_in,
  output logic                         core_accept_out,
  output logic                         mem_valid_out,
  output logic                         mem_rw_out,
  output logic [ADDR_WIDTH-1:0]        mem_addr_out,
  output logic [DATA_WIDTH-1:0]        mem_data_out,
  output logic [CREG_ID_BITS-1:0]      mem_id_out,
  input  logic                         mem_stall_in,
  input  logic                         mem_ready_in,
  input  logic [CREG_ID_BITS-1:0]      mem_id_in,
  input  logic [DATA_WIDTH-1:0]        mem_data_in,
  output logic                         core_resp_valid,
  output logic [CREG_ID_BITS-1:0]      core_resp_id,
  output logic [DATA_WIDTH-1:0]        core_resp_data,
  output logic [(1<<CREG_ID_BITS)-1:0] busy_ids,
  output logic                         err_out
);

  localparam int NUM_IDS = 1 << CREG_ID_BITS;

  typedef struct packed {
    logic                    rw;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   data;
    logic [CREG_ID_BITS-1:0] id;
  } req_t;

  localparam int REQ_W = $bits(req_t);

  req_t                    w_in;
  req_t                    w_head;
  req_t                    w_issue;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_accept;
  logic                    w_take;
  logic                    w_bypass;
  logic                    w_push;
  logic                    w_pop;
  logic [NUM_IDS-1:0]      w_set;
  logic [NUM_IDS-1:0]      w_clr;
  logic [NUM_IDS-1:0]      r_busy;
  logic                    r_err;
  logic                    r_resp_valid;
  logic [CREG_ID_BITS-1:0] r_resp_id;
  logic [DATA_WIDTH-1:0]   r_resp_data;

  assign w_in.rw   = core_rw_in;
  assign w_in.addr = core_addr_in;
  assign w_in.data = core_data_in;
  assign w_in.id   = core_id_in;

  assign w_accept = ~w_full & ~r_busy[core_id_in];
  assign w_take   = core_valid_in & w_accept;
  assign w_pop    = ~w_empty & ~mem_stall_in;

`ifdef MEM_REQ_BYPASS_EN
  assign w_bypass = w_take & w_empty & ~mem_stall_in;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push  = w_take & ~w_bypass;
  assign w_issue = w_bypass ? w_in : w_head;

  mem_req_fifo #(
    .WIDTH      (REQ_W),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign core_accept_out = w_accept;
  assign mem_valid_out   = w_pop | w_bypass;
  assign mem_rw_out      = w_issue.rw;
  assign mem_addr_out    = w_issue.addr;
  assign mem_data_out    = w_issue.data;
  assign mem_id_out      = w_issue.id;

  // Busy set/clear: stores free at issue, loads on cache ack.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_take && !(w_bypass && core_rw_in))
      w_set[core_id_in] = 1'b1;
    if (w_pop && w_head.rw)
      w_clr[w_head.id] = 1'b1;
    if (mem_ready_in && r_busy[mem_id_in])
      w_clr[mem_id_in] = 1'b1;
  end

  // Busy scoreboard and sticky error on unexpected acks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
      if (mem_ready_in && !r_busy[mem_id_in])
        r_err <= 1'b1;
    end
  end

  // One-cycle registered response to the core.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= mem_ready_in;
      if (mem_ready_in) begin
        r_resp_id   <= mem_id_in;
        r_resp_data <= mem_data_in;
      end
    end
  end

  assign core_resp_valid = r_resp_valid;
  assign core_resp_id    = r_resp_id;
  assign core_resp_data  = r_resp_data;
  assign busy_ids        = r_busy;
  assign err_out         = r_err;

endmodule

// File: tb/tb_mem_req_queue.sv
// tb_mem_req_queue: directed checks of the request queue,
// default build (no bypass).
module tb_mem_req_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_valid_in;
  logic        core_rw_in;
  logic [31:0] core_addr_in;
  logic [31:0] core_data_in;
  logic [2:0]  core_id_in;
  logic        core_accept_out;
  logic        mem_valid_out;
  logic        mem_rw_out;
  logic [31:0] mem_addr_out;
  logic [31:0] mem_data_out;
  logic [2:0]  mem_id_out;
  logic        mem_stall_in;
  logic        mem_ready_in;
  logic [2:0]  mem_id_in;
  logic [31:0] mem_data_in;
  logic        core_resp_valid;
  logic [2:0]  core_resp_id;
  logic [31:0] core_resp_data;
  logic [7:0]  busy_ids;
  logic        err_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_req_queue dut (
    .clk             (clk),
    .reset           (reset),
    .core_valid_in   (core_valid_in),
    .core_rw_in      (core_rw_in),
    .core_addr_in    (core_addr_in),
    .core_data_in    (core_data_in),
    .core_id_in      (core_id_in),
    .core_accept_out (core_accept_out),
    .mem_valid_out   (mem_valid_out),
    .mem_rw_out      (mem_rw_out),
    .mem_addr_out    (mem_addr_out),
    .mem_data_out    (mem_data_out),
    .mem_id_out      (mem_id_out),
    .mem_stall_in    (mem_stall_in),
    .mem_ready_in    (mem_ready_in),
    .mem_id_in       (mem_id_in),
    .mem_data_in     (mem_data_in),
    .core_resp_valid (core_resp_valid),
    .core_resp_id    (core_resp_id),
    .core_resp_data  (core_resp_data),
    .busy_ids        (busy_ids),
    .err_out         (err_out)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic rw,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] id);
    core_valid_in = v;
    core_rw_in    = rw;
    core_addr_in  = a;
    core_data_in  = d;
    core_id_in    = id;
  endtask

  task automatic ack(input logic r, input logic [2:0] id,
                     input logic [31:0] d);
    mem_ready_in = r;
    mem_id_in    = id;
    mem_data_in  = d;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset        = 1'b0;
    mem_stall_in = 1'b0;
    offer(0, 0, 0, 0, 0);
    ack(0, 0, 0);
    #2;
    chk("rst_mem_valid", mem_valid_out, 0);
    chk("rst_busy", busy_ids, 0);
    chk("rst_err", err_out, 0);
    chk("rst_resp_valid", core_resp_valid, 0);
    chk("rst_accept", core_accept_out, 1);
    #10 reset = 1'b1;
    tick();

    // single load
    offer(1, 0, 32'h100, 0, 3'd2);
    #1;
    chk("ld_accept", core_accept_out, 1);
    chk("ld_no_issue_c0", mem_valid_out, 0);
    tick();
    offer(0, 0, 0, 0, 0);
    #1;
    chk("ld_issue_valid", mem_valid_out, 1);
    chk("ld_issue_addr", mem_addr_out, 32'h100);
    chk("ld_issue_id", mem_id_out, 2);
    chk("ld_busy", busy_ids, 8'h04);
    tick();
    ack(1, 3'd2, 32'hDEADBEEF);
    #1;
    chk("ld_popped", mem_valid_out, 0);
    chk("ld_resp_early", core_resp_valid, 0);
    tick();
    ack(0, 0, 0);
    #1;
    chk("ld_resp_valid", core_resp_valid, 1);
    chk("ld_resp_id", core_resp_id, 2);
    chk("ld_resp_data", core_resp_data, 32'hDEADBEEF);
    chk("ld_busy_clr", busy_ids, 0);
    chk("ld_err", err_out, 0);
    tick();
    chk("ld_resp_pulse", core_resp_valid, 0);

    // full under stall
    mem_stall_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      offer(1, 0, 32'(i * 16), 0, 3'(i));
      #1;
      chk($sformatf("full_accept_%0d", i), core_accept_out, (i < 4));
      chk("full_stalled", mem_valid_out, 0);
      tick();
    end
    offer(0, 0, 0, 0, 0);
    #1;
    chk("full_busy", busy_ids, 8'h0F);
    chk("full_head_id", mem_id_out, 0);
    tick();
    chk("full_head_stable", mem_id_out, 0);
    mem_stall_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("drain_valid_%0d", k), mem_valid_out, 1);
      chk($sformatf("drain_id_%0d", k), mem_id_out, k);
      chk($sformatf("drain_addr_%0d", k), mem_addr_out, k * 16);
      tick();
    end
    chk("drain_empty", mem_valid_out, 0);
    for (int k = 0; k < 4; k++) begin
      ack(1, 3'(k), 32'(k + 32'h10));
      tick();
      chk($sformatf("full_resp_%0d", k), core_resp_id, k);
      chk($sformatf("full_rdata_%0d", k), core_resp_data, k + 16);
    end
    ack(0, 0, 0);
    #1;
    chk("full_busy_done", busy_ids, 0);
    tick();

    // ID reuse and same-cycle collision
    offer(1, 0, 32'h200, 0, 3'd1);
    #1;
    chk("reuse_first", core_accept_out, 1);
    tick();
    offer(0, 0, 0, 0, 0);
    #1;
    chk("reuse_issue", mem_id_out, 1);
    tick();
    offer(1, 0, 32'h204, 0, 3'd1);
    #1;
    chk("reuse_reject1", core_accept_out, 0);
    tick();
    chk("reuse_reject2", core_accept_out, 0);
    ack(1, 3'd1, 32'h11);
    #1;
    chk("reuse_collide", core_accept_out, 0);
    tick();
    ack(0, 0, 0);
    #1;
    chk("reuse_after_ack", core_accept_out, 1);
    chk("reuse_resp", core_resp_valid, 1);
    tick();
    offer(0, 0, 0, 0, 0);
    #1;
    chk("reuse_busy_again", busy_ids, 8'h02);
    chk("reuse_issue2", mem_addr_out, 32'h204);
    tick();
    ack(1, 3'd1, 0);
    tick();
    ack(0, 0, 0);
    #1;
    chk("reuse_clean", busy_ids, 0);

    // store: frees at issue, no response
    offer(1, 1, 32'h300, 32'h55, 3'd4);
    #1;
    chk("st_accept", core_accept_out, 1);
    tick();
    offer(1, 0, 32'h304, 0, 3'd4);
    #1;
    chk("st_issue", mem_valid_out, 1);
    chk("st_rw", mem_rw_out, 1);
    chk("st_data", mem_data_out, 32'h55);
    chk("st_busy", busy_ids, 8'h10);
    chk("st_collide", core_accept_out, 0);
    tick();
    #1;
    chk("st_busy_clr", busy_ids, 0);
    chk("st_no_resp", core_resp_valid, 0);
    chk("st_accept_next", core_accept_out, 1);
    offer(0, 0, 0, 0, 0);
    tick();

    // spurious response
    ack(1, 3'd6, 32'h66);
    tick();
    ack(0, 0, 0);
    #1;
    chk("sp_resp_valid", core_resp_valid, 1);
    chk("sp_resp_id", core_resp_id, 6);
    chk("sp_err", err_out, 1);
    chk("sp_busy", busy_ids, 0);
    tick();
    tick();
    chk("sp_err_sticky", err_out, 1);

    // reset mid-operation
    offer(1, 0, 32'h500, 0, 3'd5);
    tick();
    offer(1, 0, 32'h600, 0, 3'd6);
    tick();
    offer(0, 0, 0, 0, 0);
    tick();
    mem_stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(1, 0, 32'(i), 0, 3'(i));
      tick();
    end
    offer(0, 0, 0, 0, 0);
    ack(1, 3'd5, 32'hAA);
    tick();
    ack(0, 0, 0);
    mem_stall_in = 1'b0;
    #1;
    chk("mid_busy", busy_ids, 8'h47);
    chk("mid_resp", core_resp_valid, 1);
    chk("mid_valid", mem_valid_out, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", mem_valid_out, 0);
    chk("mid_rst_busy", busy_ids, 0);
    chk("mid_rst_err", err_out, 0);
    chk("mid_rst_resp", core_resp_valid, 0);
    chk("mid_rst_rid", core_resp_id, 0);
    chk("mid_rst_rdata", core_resp_data, 0);
    #2 reset = 1'b1;
    tick();
    offer(1, 0, 32'h400, 0, 3'd3);
    #1;
    chk("post_accept", core_accept_out, 1);
    chk("post_empty", mem_valid_out, 0);
    tick();
    offer(0, 0, 0, 0, 0);
    #1;
    chk("post_issue", mem_valid_out, 1);
    chk("post_id", mem_id_out, 3);
    chk("post_addr", mem_addr_out, 32'h400);
    chk("post_busy", busy_ids, 8'h08);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
